icache_axi_refill_unit: RTL and testbench



---
 rtl/icache_axi_refill_unit_pkg.sv | 80 ++++++++
 rtl/icache_axi_refill_unit_if.sv | 33 +++
 rtl/icache_axi_refill_unit.sv | 166 ++++++++++++++++
 tb/tb_icache_axi_refill_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_axi_refill_unit_pkg.sv
// Shared types and constants for the instruction-side AXI refill engine.
// Holds the refill FSM encoding, the AXI channel structs and the address alignment helper.
package icache_axi_refill_unit_pkg;

    localparam int ICACHE_LINE_WIDTH   = 128;
    localparam int ICACHE_REFILL_BEATS = ICACHE_LINE_WIDTH / 64;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 64;
    localparam int AXI_DATA_WIDTH = 64;

    localparam logic [3:0] ARCACHE_CACHEABLE    = 4'b0011;
    localparam logic [3:0] ARCACHE_NONCACHEABLE = 4'b0000;
    localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR      = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B          = 3'b011;
    localparam logic [2:0] AXI_PROT_INSN        = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } icache_refill_state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]   data;
        logic [AXI_DATA_WIDTH/8-1:0] strb;
        logic                        last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_resp_t;

    function automatic logic [63:0] align_down(input logic [63:0] addr, input int bytes);
        return addr & ~(64'(bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_axi_refill_unit_if.sv
// Miss-request, line-return and AXI bus bundle of the refill engine.
// The slave modport is the refill engine's view; master is the cache/interconnect side.
interface icache_axi_refill_unit_if
    import icache_axi_refill_unit_pkg::*;
#(
    parameter int AxiIdWidth = AXI_ID_WIDTH,
    parameter int LineWidth  = ICACHE_LINE_WIDTH
) ();

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [63:0]           req_addr_i;
    logic                  req_nc_i;
    logic [AxiIdWidth-1:0] req_id_i;
    logic                  rtrn_valid_o;
    logic [LineWidth-1:0]  rtrn_data_o;
    logic [AxiIdWidth-1:0] rtrn_id_o;
    logic                  rtrn_err_o;
    logic                  busy_o;
    axi_req_t              axi_req_o;
    axi_resp_t             axi_resp_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_nc_i, req_id_i, axi_resp_i,
        output req_ready_o, rtrn_valid_o, rtrn_data_o, rtrn_id_o, rtrn_err_o, busy_o, axi_req_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_nc_i, req_id_i, axi_resp_i,
        input  req_ready_o, rtrn_valid_o, rtrn_data_o, rtrn_id_o, rtrn_err_o, busy_o, axi_req_o
    );

endinterface

// File: rtl/icache_axi_refill_unit.sv
// Single-outstanding AXI read engine that turns one I$ miss into one AR burst and a full line.
// state | meaning
// IDLE  | ready for a miss request, no AXI activity
// AR    | ARVALID held with stable fields until ARREADY
// R     | collecting R beats into the line buffer until RLAST
module icache_axi_refill_unit
    import icache_axi_refill_unit_pkg::*;
#(
    parameter int AxiIdWidth = AXI_ID_WIDTH,
    parameter int LineWidth  = ICACHE_LINE_WIDTH,
    parameter int DataWidth  = AXI_DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    icache_axi_refill_unit_if.slave  bus
);

    localparam int NumBeats = LineWidth / DataWidth;
    localparam int BeatW    = $clog2(NumBeats);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

    icache_refill_state_e  r_state;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_ar_valid;
    logic                  r_r_ready;
    logic [63:0]           r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [3:0]            r_ar_cache;
    logic [AxiIdWidth-1:0] r_id;
    logic                  r_nc;
    logic [BeatW-1:0]      r_beat_cnt;
    logic                  r_err;
    logic [DataWidth-1:0]  r_line [NumBeats];
    logic                  r_rtrn_valid;
    logic [LineWidth-1:0]  r_rtrn_data;
    logic [AxiIdWidth-1:0] r_rtrn_id;
    logic                  r_rtrn_err;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [BeatW-1:0]      w_slot;
    logic                  w_last_slot;
    logic                  w_beat_err;
    logic [LineWidth-1:0]  w_line_next;
    logic                  w_unused;

    assign w_unused = ^{bus.axi_resp_i.aw_ready, bus.axi_resp_i.w_ready,
                        bus.axi_resp_i.b_valid, bus.axi_resp_i.b};

    // A beat is flagged when it carries a bad response or ID, or when RLAST disagrees
    // with the slot that should close the burst (early or missing RLAST).
    always_comb begin
        w_ar_hs     = r_ar_valid & bus.axi_resp_i.ar_ready;
        w_r_hs      = r_r_ready & bus.axi_resp_i.r_valid;
        w_slot      = r_nc ? '0 : r_beat_cnt;
        w_last_slot = r_nc ? 1'b1 : (r_beat_cnt == LastBeat);
        w_beat_err  = (bus.axi_resp_i.r.resp != AXI_RESP_OKAY) |
                      (bus.axi_resp_i.r.id != r_id) |
                      (bus.axi_resp_i.r.last != w_last_slot);
        w_line_next = '0;
        for (int k = 0; k < NumBeats; k++) begin
            w_line_next[k*DataWidth +: DataWidth] = r_line[k];
        end
        if (w_r_hs) begin
            w_line_next[int'(w_slot)*DataWidth +: DataWidth] = bus.axi_resp_i.r.data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_ar_valid   <= 1'b0;
            r_r_ready    <= 1'b0;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
            r_ar_cache   <= '0;
            r_id         <= '0;
            r_nc         <= 1'b0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_rtrn_valid <= 1'b0;
            r_rtrn_data  <= '0;
            r_rtrn_id    <= '0;
            r_rtrn_err   <= 1'b0;
            for (int k = 0; k < NumBeats; k++) begin
                r_line[k] <= '0;
            end
        end else begin
            r_rtrn_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_state     <= AR;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ar_valid  <= 1'b1;
                        r_nc        <= bus.req_nc_i;
                        r_id        <= bus.req_id_i;
                        r_ar_addr   <= bus.req_nc_i ? align_down(bus.req_addr_i, 8)
                                                    : align_down(bus.req_addr_i, LineWidth / 8);
                        r_ar_len    <= bus.req_nc_i ? 8'd0 : 8'(NumBeats - 1);
                        r_ar_cache  <= bus.req_nc_i ? ARCACHE_NONCACHEABLE : ARCACHE_CACHEABLE;
                        r_beat_cnt  <= '0;
                        r_err       <= 1'b0;
                        for (int k = 0; k < NumBeats; k++) begin
                            r_line[k] <= '0;
                        end
                    end
                end
                AR: begin
                    if (w_ar_hs) begin
                        r_state    <= R;
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                    end
                end
                R: begin
                    if (w_r_hs) begin
                        r_line[w_slot] <= bus.axi_resp_i.r.data;
                        if (r_beat_cnt != LastBeat) begin
                            r_beat_cnt <= r_beat_cnt + BeatW'(1);
                        end
                        r_err <= r_err | w_beat_err;
                        if (bus.axi_resp_i.r.last) begin
                            r_state      <= IDLE;
                            r_r_ready    <= 1'b0;
                            r_busy       <= 1'b0;
                            r_req_ready  <= 1'b1;
                            r_rtrn_valid <= 1'b1;
                            r_rtrn_data  <= w_line_next;
                            r_rtrn_id    <= r_id;
                            r_rtrn_err   <= r_err | w_beat_err;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.axi_req_o          = '0;
        bus.axi_req_o.b_ready  = 1'b1;
        bus.axi_req_o.ar_valid = r_ar_valid;
        bus.axi_req_o.ar.id    = r_id;
        bus.axi_req_o.ar.addr  = r_ar_addr;
        bus.axi_req_o.ar.len   = r_ar_len;
        bus.axi_req_o.ar.size  = AXI_SIZE_8B;
        bus.axi_req_o.ar.burst = AXI_BURST_INCR;
        bus.axi_req_o.ar.lock  = 1'b0;
        bus.axi_req_o.ar.cache = r_ar_cache;
        bus.axi_req_o.ar.prot  = AXI_PROT_INSN;
        bus.axi_req_o.r_ready  = r_r_ready;
    end

    assign bus.req_ready_o  = r_req_ready;
    assign bus.busy_o       = r_busy;
    assign bus.rtrn_valid_o = r_rtrn_valid;
    assign bus.rtrn_data_o  = r_rtrn_data;
    assign bus.rtrn_id_o    = r_rtrn_id;
    assign bus.rtrn_err_o   = r_rtrn_err;

endmodule

// File: tb/tb_icache_axi_refill_unit.sv
// Scoreboard bench for the refill engine: directed requests push expected AR and line
// returns into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_icache_axi_refill_unit;
    import icache_axi_refill_unit_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [3:0]  cache;
        logic [3:0]  id;
        int          vcyc;
    } exp_ar_t;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   id;
        logic         err;
    } exp_rt_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   ar_cycles;
    logic rlast_seen;
    exp_ar_t exp_ar_q[$];
    exp_rt_t exp_rt_q[$];
    int      pulse_hist[$];

    icache_axi_refill_unit_if bus ();

    icache_axi_refill_unit dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(posedge clk) begin
        cyc++;
        rlast_seen = rst_n & bus.axi_resp_i.r_valid & bus.axi_req_o.r_ready & bus.axi_resp_i.r.last;
    end

    // AR monitor: fields must match the expected head every cycle ARVALID is up
    always @(negedge clk) begin
        if (rst_n && bus.axi_req_o.ar_valid) begin
            if (exp_ar_q.size() == 0) begin
                timeout("ar_unexpected");
            end else begin
                ar_cycles++;
                chk("ar_fields",
                    {bus.axi_req_o.ar.addr, bus.axi_req_o.ar.len, bus.axi_req_o.ar.cache,
                     bus.axi_req_o.ar.id, bus.axi_req_o.ar.size, bus.axi_req_o.ar.burst,
                     bus.axi_req_o.ar.prot, bus.axi_req_o.ar.lock},
                    {exp_ar_q[0].addr, exp_ar_q[0].len, exp_ar_q[0].cache, exp_ar_q[0].id,
                     3'b011, 2'b01, 3'b100, 1'b0});
                if (bus.axi_resp_i.ar_ready) begin
                    chk("ar_valid_cycles", ar_cycles, exp_ar_q[0].vcyc);
                    void'(exp_ar_q.pop_front());
                    ar_cycles = 0;
                end
            end
        end
    end

    // Return monitor: pulse exactly one cycle after RLAST handshake, then scoreboard compare
    always @(negedge clk) begin
        if (rst_n) begin
            if (rlast_seen || bus.rtrn_valid_o)
                chk("rtrn_latency", bus.rtrn_valid_o, rlast_seen);
            if (bus.rtrn_valid_o) begin
                pulse_hist.push_back(cyc);
                if (exp_rt_q.size() == 0) begin
                    timeout("rtrn_unexpected");
                end else begin
                    chk("rtrn_data", bus.rtrn_data_o, exp_rt_q[0].data);
                    chk("rtrn_id", bus.rtrn_id_o, exp_rt_q[0].id);
                    chk("rtrn_err", bus.rtrn_err_o, exp_rt_q[0].err);
                    chk("pulse_idle", {bus.busy_o, bus.req_ready_o}, 2'b01);
                    void'(exp_rt_q.pop_front());
                end
            end
        end
    end

    task automatic expect_txn(input logic [63:0] ar_addr, input logic [7:0] len,
                              input logic [3:0] cache, input logic [3:0] id, input int vcyc,
                              input logic with_rtrn, input logic [127:0] data, input logic err);
        exp_ar_t a;
        exp_rt_t r;
        a.addr = ar_addr; a.len = len; a.cache = cache; a.id = id; a.vcyc = vcyc;
        exp_ar_q.push_back(a);
        if (with_rtrn) begin
            r.data = data; r.id = id; r.err = err;
            exp_rt_q.push_back(r);
        end
    endtask

    task automatic send_req(input logic [63:0] a, input logic nc, input logic [3:0] id,
                            output int acc);
        int  n;
        bit  ok;
        n = 0; ok = 0; acc = -1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_nc_i    = nc;
        bus.req_id_i    = id;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus.req_ready_o) begin ok = 1; acc = cyc; end
            else n++;
        end
        if (!ok) timeout("req_accept");
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic ar_phase(input int delay);
        int n;
        n = 0;
        while (!bus.axi_req_o.ar_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("ar_valid_wait");
        for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
        bus.axi_resp_i.ar_ready = 1'b1;
        @(posedge clk); #1;
        bus.axi_resp_i.ar_ready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic [3:0] id,
                          input logic last);
        int n;
        n = 0;
        while (!bus.axi_req_o.r_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) timeout("r_ready_wait");
        bus.axi_resp_i.r_valid = 1'b1;
        bus.axi_resp_i.r.data  = d;
        bus.axi_resp_i.r.resp  = resp;
        bus.axi_resp_i.r.id    = id;
        bus.axi_resp_i.r.last  = last;
        @(posedge clk); #1;
        bus.axi_resp_i.r_valid = 1'b0;
        bus.axi_resp_i.r.last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready_o, 1'b1);
        chk({tag, "_busy"}, bus.busy_o, 1'b0);
        chk({tag, "_rtrn_valid"}, bus.rtrn_valid_o, 1'b0);
        chk({tag, "_rtrn_data"}, bus.rtrn_data_o, 128'h0);
        chk({tag, "_rtrn_id_err"}, {bus.rtrn_id_o, bus.rtrn_err_o}, 5'h0);
        chk({tag, "_ar_r"}, {bus.axi_req_o.ar_valid, bus.axi_req_o.r_ready}, 2'b00);
        chk({tag, "_aw_w_b"}, {bus.axi_req_o.aw_valid, bus.axi_req_o.w_valid, bus.axi_req_o.b_ready}, 3'b001);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc1, acc2;
        n_checks = 0; n_pass = 0; cyc = 0; ar_cycles = 0; rlast_seen = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_nc_i    = 1'b0;
        bus.req_id_i    = '0;
        bus.axi_resp_i  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // cacheable refill, ARREADY after 3 cycles
        expect_txn(64'h8000_1230, 8'd1, 4'b0011, 4'd0, 4, 1'b1, {64'hA1, 64'hA0}, 1'b0);
        send_req(64'h8000_1238, 1'b0, 4'd0, acc1);
        ar_phase(3);
        r_beat(64'hA0, AXI_RESP_OKAY, 4'd0, 1'b0);
        r_beat(64'hA1, AXI_RESP_OKAY, 4'd0, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("rtrn_hold", bus.rtrn_data_o, {64'hA1, 64'hA0});

        // non-cacheable single beat
        expect_txn(64'h1000_0000, 8'd0, 4'b0000, 4'd3, 1, 1'b1, {64'h0, 64'hDEAD}, 1'b0);
        send_req(64'h1000_0004, 1'b1, 4'd3, acc1);
        ar_phase(0);
        r_beat(64'hDEAD, AXI_RESP_OKAY, 4'd3, 1'b1);
        repeat (2) @(posedge clk); #1;

        // SLVERR on beat 0
        expect_txn(64'h0000_2000, 8'd1, 4'b0011, 4'd5, 2, 1'b1, {64'h22, 64'h11}, 1'b1);
        send_req(64'h0000_2008, 1'b0, 4'd5, acc1);
        ar_phase(1);
        r_beat(64'h11, AXI_RESP_SLVERR, 4'd5, 1'b0);
        r_beat(64'h22, AXI_RESP_OKAY, 4'd5, 1'b1);
        repeat (2) @(posedge clk); #1;

        // back-to-back with req_valid held high
        expect_txn(64'h4000_0010, 8'd1, 4'b0011, 4'd1, 1, 1'b1, {64'hB1, 64'hB0}, 1'b0);
        expect_txn(64'h4000_0020, 8'd1, 4'b0011, 4'd2, 2, 1'b1, {64'hC1, 64'hC0}, 1'b0);
        fork
            begin
                send_req(64'h4000_0010, 1'b0, 4'd1, acc1);
                send_req(64'h4000_0028, 1'b0, 4'd2, acc2);
                @(negedge clk);
                chk("b2b_busy_after_accept", bus.busy_o, 1'b1);
            end
            begin
                ar_phase(0);
                r_beat(64'hB0, AXI_RESP_OKAY, 4'd1, 1'b0);
                r_beat(64'hB1, AXI_RESP_OKAY, 4'd1, 1'b1);
                ar_phase(1);
                r_beat(64'hC0, AXI_RESP_OKAY, 4'd2, 1'b0);
                r_beat(64'hC1, AXI_RESP_OKAY, 4'd2, 1'b1);
            end
        join
        repeat (2) @(posedge clk); #1;
        if (pulse_hist.size() >= 2) chk("b2b_accept_in_pulse", acc2, pulse_hist[pulse_hist.size()-2]);
        else timeout("b2b_pulses");

        // early RLAST on beat 0
        expect_txn(64'h5000_0000, 8'd1, 4'b0011, 4'd6, 1, 1'b1, {64'h0, 64'h77}, 1'b1);
        send_req(64'h5000_0000, 1'b0, 4'd6, acc1);
        ar_phase(0);
        r_beat(64'h77, AXI_RESP_OKAY, 4'd6, 1'b1);
        @(negedge clk);
        chk("early_idle", {bus.busy_o, bus.req_ready_o, bus.axi_req_o.r_ready}, 3'b010);
        @(posedge clk); #1;

        // missing RLAST: third beat overwrites slot 1
        expect_txn(64'h6000_0000, 8'd1, 4'b0011, 4'd7, 1, 1'b1, {64'hE2, 64'hE0}, 1'b1);
        send_req(64'h6000_0008, 1'b0, 4'd7, acc1);
        ar_phase(0);
        r_beat(64'hE0, AXI_RESP_OKAY, 4'd7, 1'b0);
        r_beat(64'hE1, AXI_RESP_OKAY, 4'd7, 1'b0);
        r_beat(64'hE2, AXI_RESP_OKAY, 4'd7, 1'b1);
        repeat (2) @(posedge clk); #1;

        // RID mismatch on beat 1
        expect_txn(64'h7000_0000, 8'd1, 4'b0011, 4'd2, 1, 1'b1, {64'hF1, 64'hF0}, 1'b1);
        send_req(64'h7000_0000, 1'b0, 4'd2, acc1);
        ar_phase(0);
        r_beat(64'hF0, AXI_RESP_OKAY, 4'd2, 1'b0);
        r_beat(64'hF1, AXI_RESP_OKAY, 4'd4, 1'b1);
        repeat (2) @(posedge clk); #1;

        // reset after one beat of the burst
        expect_txn(64'h9000_0000, 8'd1, 4'b0011, 4'd9, 1, 1'b0, 128'h0, 1'b0);
        send_req(64'h9000_0000, 1'b0, 4'd9, acc1);
        ar_phase(0);
        r_beat(64'h99, AXI_RESP_OKAY, 4'd9, 1'b0);
        rst_n = 1'b0;
        bus.axi_resp_i = '0;
        #2;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {bus.req_ready_o, bus.busy_o}, 2'b10);
        @(posedge clk); #1;

        expect_txn(64'h9000_0040, 8'd1, 4'b0011, 4'd10, 1, 1'b1, {64'h2, 64'h1}, 1'b0);
        send_req(64'h9000_0048, 1'b0, 4'd10, acc1);
        ar_phase(0);
        r_beat(64'h1, AXI_RESP_OKAY, 4'd10, 1'b0);
        r_beat(64'h2, AXI_RESP_OKAY, 4'd10, 1'b1);
        repeat (3) @(posedge clk); #1;

        chk("exp_ar_left", exp_ar_q.size(), 0);
        chk("exp_rtrn_left", exp_rt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
